// File: rtl/eh2_lsu_resv_monitor.sv
// eh2_lsu_resv_monitor: LR/SC reservation monitor for the LSU
// Ports:
//   clk, rst_l               core clock, asynchronous active-low reset
//   lr_commit_dc5/lr_addr_dc5  retired LR.W and its word address [31:2]
//   sc_req_dc3/sc_addr_dc3     SC.W in dc3 and its word address
//   sc_done_dc5              pending SC retired or killed
//   inv_valid/inv_addr       observed invalidating write and its word address
//   flush_clr                flush/interrupt/trap/mret clears the reservation
//   resv_valid/resv_addr     held reservation (address reads 0 when none)
//   sc_resp_valid_dc4/sc_fail_dc4  registered SC verdict
//   sc_busy                  SC accepted and in flight
// Optional: define RV_LSU_RESV_TIMEOUT_EN to age out reservations after RESV_TIMEOUT cycles.
module eh2_lsu_resv_monitor #(
  parameter int RESV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        lr_commit_dc5,
  input  logic [29:0] lr_addr_dc5,
  input  logic        sc_req_dc3,
  input  logic [29:0] sc_addr_dc3,
  input  logic        sc_done_dc5,
  input  logic        inv_valid,
  input  logic [29:0] inv_addr,
  input  logic        flush_clr,
  output logic        resv_valid,
  output logic [29:0] resv_addr,
  output logic        sc_resp_valid_dc4,
  output logic        sc_fail_dc4,
  output logic        sc_busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RSVD = 2'd1, SCPEND = 2'd2} state_t;
  state_t state, state_nxt;
  logic [29:0] addr_q, addr_nxt;
  logic inv_hit, sc_pass, timeout;
  if (RESV_TIMEOUT < 2 || RESV_TIMEOUT > 1024) begin : g_bad_timeout
    $error("RESV_TIMEOUT must be within 2..1024");
  end
`ifdef RV_LSU_RESV_TIMEOUT_EN
  logic [9:0] age, age_nxt;
  assign timeout = (state == RSVD) && (age == 10'(RESV_TIMEOUT - 1));
  always_comb begin
    age_nxt = lr_commit_dc5 ? 10'd0 : (state == RSVD) ? ((age == 10'h3ff) ? age : age + 10'd1) : 10'd0;
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) age <= 10'd0;
    else        age <= age_nxt;
  end
`else
  assign timeout = 1'b0;
`endif
  assign inv_hit = inv_valid && (inv_addr == addr_q);
  // a matching invalidation or flush in the SC's own cycle beats the SC
  assign sc_pass = (state == RSVD) && (sc_addr_dc3 == addr_q) && !inv_hit && !flush_clr;
  always_comb begin
    state_nxt = IDLE;
    addr_nxt  = addr_q;
    if (lr_commit_dc5) begin
      state_nxt = RSVD;
      addr_nxt  = lr_addr_dc5;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RSVD:    state_nxt = sc_req_dc3 ? (sc_pass ? SCPEND : IDLE)
                           : (inv_hit || flush_clr || timeout) ? IDLE : RSVD;
        SCPEND:  state_nxt = (sc_done_dc5 || flush_clr) ? IDLE : SCPEND;
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state             <= IDLE;
      addr_q            <= 30'd0;
      sc_resp_valid_dc4 <= 1'b0;
      sc_fail_dc4       <= 1'b0;
    end else begin
      state             <= state_nxt;
      addr_q            <= addr_nxt;
      sc_resp_valid_dc4 <= sc_req_dc3;
      sc_fail_dc4       <= sc_req_dc3 && !sc_pass;
    end
  end
  assign resv_valid = (state == RSVD);
  assign resv_addr  = resv_valid ? addr_q : 30'd0;
  assign sc_busy    = (state == SCPEND);
endmodule

// File: tb/tb_eh2_lsu_resv_monitor.sv
// tb_eh2_lsu_resv_monitor: directed self-checking bench for the LR/SC reservation monitor
module tb_eh2_lsu_resv_monitor;
  logic clk = 1'b0;
  logic rst_l;
  logic lr_commit_dc5, sc_req_dc3, sc_done_dc5, inv_valid, flush_clr;
  logic [29:0] lr_addr_dc5, sc_addr_dc3, inv_addr;
  logic resv_valid, sc_resp_valid_dc4, sc_fail_dc4, sc_busy;
  logic [29:0] resv_addr;
  int checks = 0;
  int fails = 0;
`ifdef RV_LSU_RESV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  eh2_lsu_resv_monitor #(.RESV_TIMEOUT(8)) dut (
    .clk(clk), .rst_l(rst_l),
    .lr_commit_dc5(lr_commit_dc5), .lr_addr_dc5(lr_addr_dc5),
    .sc_req_dc3(sc_req_dc3), .sc_addr_dc3(sc_addr_dc3),
    .sc_done_dc5(sc_done_dc5),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .flush_clr(flush_clr),
    .resv_valid(resv_valid), .resv_addr(resv_addr),
    .sc_resp_valid_dc4(sc_resp_valid_dc4), .sc_fail_dc4(sc_fail_dc4),
    .sc_busy(sc_busy)
  );
  always #5 clk = ~clk;
  task automatic clr_in();
    lr_commit_dc5 = 0; lr_addr_dc5 = '0; sc_req_dc3 = 0; sc_addr_dc3 = '0;
    sc_done_dc5 = 0; inv_valid = 0; inv_addr = '0; flush_clr = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    clr_in();
  endtask
  task automatic do_lr(input logic [29:0] a);
    lr_commit_dc5 = 1; lr_addr_dc5 = a;
    step();
  endtask
  task automatic test_reset();
    clr_in();
    rst_l = 0;
    #2;
    checks++; if ({resv_valid, sc_resp_valid_dc4, sc_fail_dc4, sc_busy} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b exp 0000", {resv_valid, sc_resp_valid_dc4, sc_fail_dc4, sc_busy}); end
    checks++; if (resv_addr !== 30'd0) begin fails++; $display("FAIL reset_addr: got %h exp 0", resv_addr); end
    step(); step();
    rst_l = 1;
    step();
    checks++; if ({resv_valid, sc_busy} !== 2'b0) begin fails++; $display("FAIL post_reset: got %b exp 00", {resv_valid, sc_busy}); end
  endtask
  task automatic test_lr_sc_pass();
    do_lr(30'h400);
    checks++; if (resv_valid !== 1'b1) begin fails++; $display("FAIL lr_valid: got %b exp 1", resv_valid); end
    checks++; if (resv_addr !== 30'h400) begin fails++; $display("FAIL lr_addr: got %h exp 400", resv_addr); end
    step(); step();
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if ({sc_resp_valid_dc4, sc_fail_dc4} !== 2'b10) begin fails++; $display("FAIL sc_pass_resp: got %b exp 10", {sc_resp_valid_dc4, sc_fail_dc4}); end
    checks++; if ({sc_busy, resv_valid, resv_addr} !== {2'b10, 30'd0}) begin fails++; $display("FAIL sc_pass_busy: got busy=%b rv=%b ra=%h exp 1 0 0", sc_busy, resv_valid, resv_addr); end
    step();
    checks++; if ({sc_busy, sc_resp_valid_dc4} !== 2'b10) begin fails++; $display("FAIL scpend_hold: got %b exp 10", {sc_busy, sc_resp_valid_dc4}); end
    inv_valid = 1; inv_addr = 30'h400;
    step();
    checks++; if (sc_busy !== 1'b1) begin fails++; $display("FAIL scpend_ignores_inv: got %b exp 1", sc_busy); end
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if ({sc_busy, sc_resp_valid_dc4, sc_fail_dc4} !== 3'b111) begin fails++; $display("FAIL sc_in_scpend: got %b exp 111", {sc_busy, sc_resp_valid_dc4, sc_fail_dc4}); end
    sc_done_dc5 = 1;
    step();
    checks++; if ({sc_busy, resv_valid} !== 2'b00) begin fails++; $display("FAIL sc_done: got %b exp 00", {sc_busy, resv_valid}); end
  endtask
  task automatic test_inv_race();
    do_lr(30'h400);
    inv_valid = 1; inv_addr = 30'h400; sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if ({sc_resp_valid_dc4, sc_fail_dc4, sc_busy, resv_valid} !== 4'b1100) begin fails++; $display("FAIL inv_race: got %b exp 1100", {sc_resp_valid_dc4, sc_fail_dc4, sc_busy, resv_valid}); end
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if ({sc_resp_valid_dc4, sc_fail_dc4, sc_busy} !== 3'b110) begin fails++; $display("FAIL sc_in_idle: got %b exp 110", {sc_resp_valid_dc4, sc_fail_dc4, sc_busy}); end
  endtask
  task automatic test_nonmatch_inv();
    do_lr(30'h400);
    inv_valid = 1; inv_addr = 30'h800;
    step();
    checks++; if ({resv_valid, resv_addr} !== {1'b1, 30'h400}) begin fails++; $display("FAIL nonmatch_inv: got rv=%b ra=%h exp 1 400", resv_valid, resv_addr); end
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if ({sc_fail_dc4, sc_busy} !== 2'b01) begin fails++; $display("FAIL nonmatch_sc_pass: got %b exp 01", {sc_fail_dc4, sc_busy}); end
    sc_done_dc5 = 1;
    step();
    do_lr(30'h400);
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h401;
    step();
    checks++; if ({sc_resp_valid_dc4, sc_fail_dc4, sc_busy, resv_valid} !== 4'b1100) begin fails++; $display("FAIL sc_wrong_addr: got %b exp 1100", {sc_resp_valid_dc4, sc_fail_dc4, sc_busy, resv_valid}); end
    do_lr(30'h400);
    inv_valid = 1; inv_addr = 30'h400;
    step();
    checks++; if (resv_valid !== 1'b0) begin fails++; $display("FAIL match_inv: got %b exp 0", resv_valid); end
  endtask
  task automatic test_timeout();
    do_lr(30'h400);
    for (int i = 0; i < 7; i++) step();
    checks++; if (resv_valid !== 1'b1) begin fails++; $display("FAIL timeout_cycle8: got %b exp 1", resv_valid); end
    step();
    checks++; if (resv_valid !== !TO_EN) begin fails++; $display("FAIL timeout_cycle9: got %b exp %b", resv_valid, !TO_EN); end
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if (sc_fail_dc4 !== TO_EN) begin fails++; $display("FAIL timeout_sc: got %b exp %b", sc_fail_dc4, TO_EN); end
    sc_done_dc5 = 1;
    step();
  endtask
  task automatic test_reset_scpend();
    do_lr(30'h400);
    sc_req_dc3 = 1; sc_addr_dc3 = 30'h400;
    step();
    checks++; if ({sc_busy, sc_resp_valid_dc4} !== 2'b11) begin fails++; $display("FAIL pre_rst_scpend: got %b exp 11", {sc_busy, sc_resp_valid_dc4}); end
    rst_l = 0;
    #1;
    checks++; if ({resv_valid, resv_addr, sc_resp_valid_dc4, sc_fail_dc4, sc_busy} !== 34'd0) begin fails++; $display("FAIL async_reset: got rv=%b ra=%h rsp=%b f=%b b=%b exp all 0", resv_valid, resv_addr, sc_resp_valid_dc4, sc_fail_dc4, sc_busy); end
    step();
    rst_l = 1;
    step();
    sc_done_dc5 = 1;
    step();
    checks++; if ({resv_valid, sc_resp_valid_dc4, sc_fail_dc4, sc_busy} !== 4'b0) begin fails++; $display("FAIL done_after_rst: got %b exp 0000", {resv_valid, sc_resp_valid_dc4, sc_fail_dc4, sc_busy}); end
  endtask
  task automatic test_lr_flush();
    lr_commit_dc5 = 1; lr_addr_dc5 = 30'hc00; flush_clr = 1;
    step();
    checks++; if ({resv_valid, resv_addr} !== {1'b1, 30'hc00}) begin fails++; $display("FAIL lr_beats_flush: got rv=%b ra=%h exp 1 c00", resv_valid, resv_addr); end
    do_lr(30'h123);
    checks++; if (resv_addr !== 30'h123) begin fails++; $display("FAIL lr_replace: got %h exp 123", resv_addr); end
    flush_clr = 1;
    step();
    checks++; if ({resv_valid, resv_addr} !== {1'b0, 30'd0}) begin fails++; $display("FAIL flush_clear: got rv=%b ra=%h exp 0 0", resv_valid, resv_addr); end
  endtask
  initial begin
    test_reset();
    test_lr_sc_pass();
    test_inv_race();
    test_nonmatch_inv();
    test_timeout();
    test_reset_scpend();
    test_lr_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
